add5_operand_feeder: RTL
========================

# add5_operand_feeder

Upstream stage for the 5-bit ripple adder. It buffers operand pairs and carry-in from the producer in a small FIFO and presents one pair at a time on the adder's `A`/`B`/`E`/`stop` inputs. It holds each pair until the consumer of the adder sum acknowledges it, and drives `stop` high whenever no valid pair is presented, which forces the adder sum to zero.

## Interface
- `WIDTH`, 5: operand width; must match the adder.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `push`  in  1  producer write strobe.
- `push_a`  in  WIDTH  operand A to enqueue.
- `push_b`  in  WIDTH  operand B to enqueue.
- `push_e`  in  1  carry-in/enable bit to enqueue.
- `full`  out  1  FIFO holds DEPTH entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a push is dropped.
- `halt`  in  1  freeze presentation; forces `stop`.
- `ack`  in  1  consumer has taken the current sum; pops the head.
- `A`  out  WIDTH  head operand A to adder.
- `B`  out  WIDTH  head operand B to adder.
- `E`  out  1  head carry-in to adder.
- `stop`  out  1  to adder `stop`; 1 = adder output zero.
- `pair_valid`  out  1  head pair is presented and sum is meaningful.

## Operation
- Storage: DEPTH-entry circular buffer of {a, b, e}, with write pointer, read pointer and occupancy counter. Pointers wrap modulo DEPTH.
- `pair_valid` = (count != 0) && !halt. `stop` = !pair_valid.
- `A`/`B`/`E` come combinationally from the head entry when `pair_valid` is 1. Otherwise they are all 0.
- Pop: occurs when `ack && pair_valid`. The read pointer advances and count decrements.
  - `ack` while `pair_valid` = 0 is ignored (no pop, no error).
- Push acceptance: `push && (count < DEPTH || pop)`. On acceptance, the entry is written at the write pointer, which then advances.
- Dropped push: `push` while full with no pop that cycle. The data is discarded and `overflow` is set; it stays set until reset.
- Count update for push and pop in the same cycle (both accepted): count is unchanged and both pointers advance.
- `halt` does not block pushes. It only suppresses presentation and pop.
- No arithmetic is performed here; widths pass through unchanged. The carry-out of the adder is not observed.

## Timing
- Reset (`Reset` = 0 at rising edge):
  - Pointers, count and `overflow` go to 0.
  - Outputs become `full`=0, `count`=0, `overflow`=0, `pair_valid`=0, `stop`=1, `A`=`B`=0, `E`=0.
  - Reset takes priority over `push` and `ack` in the same cycle. In-flight FIFO contents are lost when reset is applied mid-operation.
- Push-to-present latency: 1 cycle. A push accepted at edge N into an empty FIFO gives `pair_valid`=1 after edge N, with the adder inputs valid combinationally in that cycle.
- Push into an empty FIFO with `ack` high in the same cycle: the ack is ignored and the pair is presented next cycle.
- Pop: with `ack` high at edge N, the next entry is presented after edge N. Back-to-back acks give one pair per cycle.
- Simultaneous push and pop when full: both are accepted, `full` stays 1, and `overflow` is not set.
- Simultaneous push and pop at count=1: the new entry becomes the head after the edge, and `pair_valid` stays 1.
- `halt` takes effect combinationally: `stop` rises in the same cycle and pops are blocked from that cycle on. Deasserting `halt` re-presents the same head with no loss.
- `full` and `count` are registered and reflect state after the last edge.

## Test plan
- **Reset then idle:** hold `Reset`=0 for 2 cycles, then release with no stimulus. Expect `stop`=1, `pair_valid`=0, `A`=`B`=0, `E`=0, `count`=0 throughout.
- **Single pair:** push a=5'd7, b=5'd9, e=0. The next cycle shows `A`=7, `B`=9, `E`=0, `stop`=0, and the adder sums to 16. Pulse `ack`; the cycle after shows `stop`=1 and `count`=0.
- **Fill and overflow:** 5 consecutive pushes (1,1,0)…(5,5,1) with no ack. Expect `full`=1 after the 4th push and `overflow`=1 after the 5th. Popping all entries returns the pairs in order 1..4; pair 5 is absent.
- **Full plus push plus ack in the same cycle:** at `count`=4, push (31,1,1) together with `ack`. Expect `count` to remain 4, `overflow` to remain 0, and (31,1,1) to be presented as the 4th pop later.
- **Halt:** with 2 entries queued, assert `halt` for 3 cycles while `ack`=1. Expect `stop`=1, `A`=`B`=0 and `count` unchanged at 2. After `halt` drops, the head from before the halt is re-presented.
- **Reset mid-stream:** with 3 entries queued and `ack` pulsing, assert `Reset`=0 for one edge. Expect all outputs at their reset values the next cycle, and a subsequent push presented normally.

Source files
------------

// File: rtl/add5_operand_feeder.sv
// Operand FIFO feeding the 5-bit ripple adder: buffers {a,b,e} pairs and
// presents the head pair until the sum consumer acks it; stop=1 when idle.
module add5_operand_feeder #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_a,
   input  logic [WIDTH-1:0]           push_b,
   input  logic                       push_e,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       halt,
   input  logic                       ack,
   output logic [WIDTH-1:0]           A,
   output logic [WIDTH-1:0]           B,
   output logic                       E,
   output logic                       stop,
   output logic                       pair_valid
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             e;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   cnt;
   logic            ovf;
   logic            pop, acc, drop;
   entry_t          head;

   assign full       = (cnt == CW'(DEPTH));
   assign count      = cnt;
   assign overflow   = ovf;
   assign pair_valid = (cnt != '0) && !halt;
   assign stop       = !pair_valid;

   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign pop  = ack && pair_valid;
   assign acc  = push && (!full || pop);
   assign drop = push && !acc;

   assign head = mem[rptr];
   assign A    = pair_valid ? head.a : '0;
   assign B    = pair_valid ? head.b : '0;
   assign E    = pair_valid ? head.e : 1'b0;

   // Storage has no reset; only pointers/count define what is valid.
   always_ff @(posedge clk) begin
      if (Reset && acc)
         mem[wptr] <= '{a: push_a, b: push_b, e: push_e};
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (acc) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         case ({acc, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (drop) ovf <= 1'b1;
      end
   end
endmodule
